// File: rtl/lsu_pkg.sv
//------------------------------------------------------------------------------
// Module : lsu_pkg
// Brief  : Shared access-size codes and FSM state type for the load/store unit.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_WR = 2'd1,
        DONE   = 2'd2
    } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
//------------------------------------------------------------------------------
// Module : lsu_align
// Brief  : Byte-lane extraction/extension for loads, lane merge for sub-word
//          stores, and size/alignment legality checks. Purely combinational.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_align (
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_size,
    input  logic        i_we,
    input  logic [31:0] i_raw,
    input  logic [31:0] i_wd,
    output logic [31:0] o_load_val,
    output logic [31:0] o_merged,
    output logic        o_misaligned,
    output logic        o_illegal
);
    import lsu_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_raw[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];

    always_comb begin
        o_load_val   = '0;
        o_merged     = i_wd;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        case (i_size)
            LS_B: begin
                o_load_val = {{24{w_byte[7]}}, w_byte};
                o_merged   = i_raw;
                o_merged[{i_addr_lo, 3'b000} +: 8] = i_wd[7:0];
            end
            LS_H: begin
                o_load_val   = {{16{w_half[15]}}, w_half};
                o_merged     = i_raw;
                o_misaligned = i_addr_lo[0];
                if (i_addr_lo[1]) begin
                    o_merged[31:16] = i_wd[15:0];
                end else begin
                    o_merged[15:0]  = i_wd[15:0];
                end
            end
            LS_W: begin
                o_load_val   = i_raw;
                o_misaligned = |i_addr_lo;
            end
            // Unsigned sizes only make sense for loads
            LS_BU: begin
                o_load_val = {24'd0, w_byte};
                o_illegal  = i_we;
            end
            LS_HU: begin
                o_load_val   = {16'd0, w_half};
                o_misaligned = i_addr_lo[0];
                o_illegal    = i_we;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
//------------------------------------------------------------------------------
// Module : lsu_ctrl
// Brief  : Load/store controller bridging sized byte-addressed core requests
//          to a word-only memory; sub-word stores use read-modify-write.
// Config : define LSU_RANGE_CHECK_EN to fault out-of-range addresses and add
//          the access_fault_o port.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_ctrl #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misaligned_o,
    output logic        illegal_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
`ifdef LSU_RANGE_CHECK_EN
    ,
    output logic        access_fault_o
`endif
);
    import lsu_pkg::*;

    lsu_state_e  r_state;
    logic [31:0] r_rd;
    logic [31:0] r_merge;
    logic        r_misaligned;
    logic        r_illegal;

    logic        w_idle_req;
    logic        w_fault;
    logic        w_err;
    logic        w_sw;
    logic [31:0] w_raw;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;
    logic        w_misaligned;
    logic        w_illegal;
    logic [IDX_W-1:0] w_idx;

`ifdef LSU_RANGE_CHECK_EN
    logic r_fault;
    assign w_fault        = (core_addr_i[31:2] >= 30'(DEPTH));
    assign access_fault_o = r_fault;
`else
    logic w_unused_hi;
    assign w_fault     = 1'b0;
    assign w_unused_hi = ^core_addr_i[31:IDX_W+2];
`endif

    // During RMW_WR the merge source is the word latched on the read cycle
    assign w_raw = (r_state == RMW_WR) ? r_merge : mem_rd_i;

    lsu_align u_align (
        .i_addr_lo    (core_addr_i[1:0]),
        .i_size       (core_size_i),
        .i_we         (core_we_i),
        .i_raw        (w_raw),
        .i_wd         (core_wd_i),
        .o_load_val   (w_load_val),
        .o_merged     (w_merged),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    assign w_idle_req = (r_state == IDLE) && core_req_i;
    assign w_err      = w_illegal | w_misaligned | w_fault;
    assign w_sw       = core_we_i && (core_size_i == LS_W);
    assign w_idx      = core_addr_i[IDX_W+1:2];

    // Memory strobes are gated by reset so an abandoned RMW never writes
    assign mem_req_o  = !rst_i && ((w_idle_req && !w_err) || (r_state == RMW_WR));
    assign mem_we_o   = !rst_i && ((w_idle_req && !w_err && w_sw) || (r_state == RMW_WR));
    assign mem_addr_o = mem_req_o ? {{(32-IDX_W){1'b0}}, w_idx} : 32'd0;
    assign mem_wd_o   = !mem_we_o ? 32'd0 : ((r_state == RMW_WR) ? w_merged : core_wd_i);

    assign core_stall_o = w_idle_req || (r_state == RMW_WR);
    assign core_rd_o    = r_rd;
    assign misaligned_o = r_misaligned;
    assign illegal_o    = r_illegal;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_rd         <= '0;
            r_merge      <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
`ifdef LSU_RANGE_CHECK_EN
            r_fault      <= 1'b0;
`endif
        end else begin
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
`ifdef LSU_RANGE_CHECK_EN
            r_fault      <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (core_req_i) begin
                        if (w_err) begin
                            r_illegal    <= w_illegal;
                            r_misaligned <= !w_illegal && w_misaligned;
`ifdef LSU_RANGE_CHECK_EN
                            r_fault      <= !w_illegal && !w_misaligned && w_fault;
`endif
                            if (!core_we_i) begin
                                r_rd <= '0;
                            end
                            r_state <= DONE;
                        end else if (!core_we_i) begin
                            r_rd    <= w_load_val;
                            r_state <= DONE;
                        end else if (w_sw) begin
                            r_state <= DONE;
                        end else begin
                            r_merge <= mem_rd_i;
                            r_state <= RMW_WR;
                        end
                    end
                end
                RMW_WR:  r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_lsu_ctrl
// Brief  : Directed plus randomized checks of lsu_ctrl against a byte-level
//          reference memory model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall;
    logic        mis;
    logic        ill;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [31:0] mrd;
`ifdef LSU_RANGE_CHECK_EN
    logic        fault;
`endif

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        sync_ram = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          n_cmp  = 0;
    int          n_err  = 0;
    logic [31:0] exp_rd;

    lsu_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .core_req_i   (req),
        .core_we_i    (we),
        .core_size_i  (size),
        .core_addr_i  (addr),
        .core_wd_i    (wd),
        .core_rd_o    (rd),
        .core_stall_o (stall),
        .misaligned_o (mis),
        .illegal_o    (ill),
        .mem_req_o    (mreq),
        .mem_we_o     (mwe),
        .mem_addr_o   (maddr),
        .mem_wd_o     (mwd),
        .mem_rd_i     (mrd)
`ifdef LSU_RANGE_CHECK_EN
        ,
        .access_fault_o (fault)
`endif
    );

    always #5 clk = ~clk;

    assign mrd = ram[maddr[9:0]];

    always @(posedge clk) begin
        if (sync_ram) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= ref_mem[i];
        end else if (mreq) begin
            if (mwe) begin
                ram[maddr[9:0]] <= mwd;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] s);
        if (s == LS_W) return 4;
        if (s == LS_H || s == LS_HU) return 2;
        return 1;
    endfunction

    function automatic logic bad_size(input logic w, input logic [2:0] s);
        if (s == 3'b011 || s == 3'b110 || s == 3'b111) return 1'b1;
        return w && (s == LS_BU || s == LS_HU);
    endfunction

    // One complete request: drive, count stall cycles, check the DONE cycle
    task automatic op(input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        int stalls, rd0, wr0, n, off, idx, exp_stalls, exp_r, exp_w;
        logic e_ill, e_mis, e_flt, ok;
        logic [31:0] word, v, mask;
        @(negedge clk);
        req = 1'b1; we = w; size = s; addr = a; wd = d;
        #1;
        chk("pulse_clear_mis", {31'd0, mis}, 32'd0);
        chk("pulse_clear_ill", {31'd0, ill}, 32'd0);
        rd0 = rd_cnt; wr0 = wr_cnt;
        stalls = 0;
        while (stall && stalls < 8) begin
            stalls++;
            @(negedge clk); #1;
        end

        n     = nbytes(s);
        off   = int'(a % 4);
        idx   = int'((a / 4) % DEPTH);
        e_ill = bad_size(w, s);
        e_mis = !e_ill && ((a % n) != 0);
`ifdef LSU_RANGE_CHECK_EN
        e_flt = !e_ill && !e_mis && ((a / 4) >= DEPTH);
`else
        e_flt = 1'b0;
`endif
        ok         = !(e_ill || e_mis || e_flt);
        exp_stalls = (ok && w && n < 4) ? 2 : 1;
        exp_r      = (ok && (!w || n < 4)) ? 1 : 0;
        exp_w      = (ok && w) ? 1 : 0;

        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        chk("mem_reads", 32'(rd_cnt - rd0), 32'(exp_r));
        chk("mem_writes", 32'(wr_cnt - wr0), 32'(exp_w));
        chk("misaligned", {31'd0, mis}, {31'd0, e_mis});
        chk("illegal", {31'd0, ill}, {31'd0, e_ill});
`ifdef LSU_RANGE_CHECK_EN
        chk("access_fault", {31'd0, fault}, {31'd0, e_flt});
`endif
        word = ref_mem[idx];
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        if (!w) begin
            v = (word >> (8 * off)) & mask;
            if (s[2] == 1'b0 && n < 4 && v[8 * n - 1]) v = v | ~mask;
            exp_rd = ok ? v : 32'd0;
            chk("load_data", rd, exp_rd);
        end else begin
            if (ok) begin
                for (int k = 0; k < n; k++) word[8 * (off + k) +: 8] = d[8 * k +: 8];
                ref_mem[idx] = word;
            end
            chk("ram_word", ram[idx], ref_mem[idx]);
            chk("rd_held", rd, exp_rd);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_mreq", {31'd0, mreq}, 32'd0);
    endtask

    logic [2:0] sz_tbl [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3, 3'd6, 3'd7};

    initial begin
        int wr0;
        logic [2:0] s;
        logic [31:0] a;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 3'd0; addr = '0; wd = '0;
        exp_rd = 32'd0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom();
        ref_mem[5]  = 32'h8899AABB;
        ref_mem[2]  = 32'h11223344;
        ref_mem[16] = 32'hCAFE0001;
        sync_ram = 1'b1;
        @(negedge clk);
        sync_ram = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_core_rd", rd, 32'd0);
        chk("rst_mem_req", {31'd0, mreq}, 32'd0);
        chk("rst_mem_we", {31'd0, mwe}, 32'd0);
        chk("rst_mem_addr", maddr, 32'd0);
        chk("rst_mem_wd", mwd, 32'd0);
        chk("rst_flags", {30'd0, mis, ill}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;

        // Sign/zero extension of the top byte lane
        op(1'b0, LS_B, 32'h17, 32'd0);
        chk("tp_lb", rd, 32'hFFFFFF88);
        op(1'b0, LS_BU, 32'h17, 32'd0);
        chk("tp_lbu", rd, 32'h00000088);
        idle_cycle();

        op(1'b1, LS_B, 32'h09, 32'hDEADBEEF);
        chk("tp_sb_word", ram[2], 32'h1122EF44);
        idle_cycle();

        op(1'b0, LS_H, 32'h03, 32'd0);
        op(1'b1, LS_W, 32'h06, 32'h12345678);
        op(1'b0, 3'b111, 32'h40, 32'd0);
        op(1'b1, LS_W, 32'h10, 32'hA5A5_0F0F);
        op(1'b0, LS_W, 32'h10, 32'd0);
        chk("tp_b2b", rd, 32'hA5A5_0F0F);
        op(1'b0, LS_W, 32'h1000, 32'd0);
        op(1'b1, LS_BU, 32'h44, 32'h1);
        idle_cycle();

        // Reset while the RMW write is pending must abandon the write
        op(1'b0, LS_W, 32'h40, 32'd0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = LS_H; addr = 32'h20; wd = 32'h0000BEEF;
        wr0 = wr_cnt;
        @(negedge clk); #1;
        chk("rmw_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rmw_rst_we", {31'd0, mwe}, 32'd0);
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        #1;
        exp_rd = 32'd0;
        chk("rmw_rst_rd", rd, 32'd0);
        chk("rmw_rst_writes", 32'(wr_cnt - wr0), 32'd0);
        chk("rmw_rst_word", ram[8], ref_mem[8]);
        chk("rmw_rst_mem", {mreq, mwe, 30'd0} | maddr | mwd, 32'd0);
        chk("rmw_rst_flags", {29'd0, stall, mis, ill}, 32'd0);

        for (int t = 0; t < 200; t++) begin
            s = sz_tbl[$urandom_range(0, 9)];
            a = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(s) - 1);
            op(1'($urandom_range(0, 1)), s, a, $urandom());
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
